dilated_tap_scheduler: RTL and testbench



---
 rtl/dilated_tap_scheduler_if.sv | 47 ++++
 rtl/dilated_tap_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_dilated_tap_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dilated_tap_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : dilated_tap_scheduler_if
//  Description : Bundle of the upstream stream, the conv1d control/tap bus
//                and the downstream result signals of dilated_tap_scheduler.
//                'slave' is the scheduler's view, 'master' is the view of
//                whatever surrounds it (upstream producer + conv1d + sink).
//  Revision    : 1.0  initial release
// ============================================================================
interface dilated_tap_scheduler_if #(
  parameter int W = 16,
  parameter int D = 8
);
  // Upstream stream
  logic             in_v;
  logic             in_ready;
  logic [D*W-1:0]   in_data;
  logic             relu_en;
  // conv1d side
  logic             conv_rst;
  logic             conv_apply_relu;
  logic [D*W-1:0]   conv_a0;
  logic [D*W-1:0]   conv_a1;
  logic [D*W-1:0]   conv_a2;
  logic [D*W-1:0]   conv_a3;
  logic [D*W-1:0]   conv_out;
  logic             conv_out_v;
  // Downstream result
  logic             out_v;
  logic [D*W-1:0]   out_data;
  logic [15:0]      sample_count;

  modport master (
    output in_v, in_data, relu_en, conv_out, conv_out_v,
    input  in_ready, conv_rst, conv_apply_relu,
    input  conv_a0, conv_a1, conv_a2, conv_a3,
    input  out_v, out_data, sample_count
  );

  modport slave (
    input  in_v, in_data, relu_en, conv_out, conv_out_v,
    output in_ready, conv_rst, conv_apply_relu,
    output conv_a0, conv_a1, conv_a2, conv_a3,
    output out_v, out_data, sample_count
  );
endinterface
`default_nettype wire

// File: rtl/dilated_tap_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : dilated_tap_scheduler
//  Description : Keeps the last 3*DILATION+1 activation vectors in a ring and,
//                per accepted timestep, presents the dilated taps
//                x[t-3K], x[t-2K], x[t-K], x[t] to a conv1d instance, pulses
//                the conv's reset, waits for its result and forwards it as a
//                one-cycle valid.
//                Optional feature macro DTS_ZERO_PAD_EN: causal zero padding
//                of taps that reach before the first sample, and a ring that
//                is cleared on reset.
//  Revision    : 1.0  initial release
// ============================================================================
module dilated_tap_scheduler #(
  parameter int W        = 16,
  parameter int D        = 8,
  parameter int DILATION = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  dilated_tap_scheduler_if.slave  dts_io
);

  localparam int DEPTH = 3 * DILATION + 1;
  localparam int DW    = D * W;
  localparam int AW    = $clog2(DEPTH);       // ring address width
  localparam int FW    = $clog2(DEPTH + 1);   // fill level needs to hold DEPTH
  localparam int NTAP  = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_CONV_RST = 3'd2,
    S_WAIT     = 3'd3,
    S_EMIT     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wp_q, wp_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [15:0]     count_q, count_d;
  logic            conv_rst_q;
  logic [DW-1:0]   ring_q [DEPTH];
  logic [DW-1:0]   tap_q  [NTAP];
  logic [DW-1:0]   tap_d  [NTAP];
  logic            w_accept;

  // Ring slot of the sample OFF timesteps back from the slot just written.
  // Adding DEPTH first keeps the subtraction non-negative; since OFF never
  // exceeds DEPTH-1 a single conditional subtract completes the modulo.
  function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] wp,
                                             input int          off);
    logic [AW:0] sum;
    sum = {1'b0, wp} + (AW+1)'(DEPTH) - (AW+1)'(off);
    if (sum >= (AW+1)'(DEPTH)) begin
      sum = sum - (AW+1)'(DEPTH);
    end
    return sum[AW-1:0];
  endfunction

  assign w_accept = (state_q == S_IDLE) && dts_io.in_v;

  // Next-state and datapath update decisions for the sequencing FSM
  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    fill_d     = fill_q;
    out_data_d = out_data_q;
    count_d    = count_q;
    case (state_q)
      S_IDLE: begin
        if (dts_io.in_v) begin
          if (fill_q != FW'(DEPTH)) begin
            fill_d = fill_q + FW'(1);
          end
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Advance only after the taps have been read relative to the slot
        // written in IDLE, so x[t] is always at offset 0 from wp_q here.
        if (wp_q == AW'(DEPTH - 1)) begin
          wp_d = '0;
        end else begin
          wp_d = wp_q + AW'(1);
        end
        state_d = S_CONV_RST;
      end
      S_CONV_RST: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The conv was reset in the previous cycle, so a stale out_v from
        // the last timestep cannot be seen here.
        if (dts_io.conv_out_v) begin
          out_data_d = dts_io.conv_out;
          state_d    = S_EMIT;
        end
      end
      S_EMIT: begin
        count_d = count_q + 16'd1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Tap selection from the ring, optionally zero-padded before the first sample
  always_comb begin
    for (int n = 0; n < NTAP; n++) begin
      tap_d[n] = ring_q[tap_addr(wp_q, (3 - n) * DILATION)];
`ifdef DTS_ZERO_PAD_EN
      // fill_q already counts the sample written in IDLE
      if (FW'((3 - n) * DILATION) >= fill_q) begin
        tap_d[n] = '0;
      end
`endif
    end
  end

  // FSM state, pointers, counters and the registered conv reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wp_q       <= '0;
      fill_q     <= '0;
      out_data_q <= '0;
      count_q    <= '0;
      conv_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      fill_q     <= fill_d;
      out_data_q <= out_data_d;
      count_q    <= count_d;
      conv_rst_q <= (state_d == S_CONV_RST);
    end
  end

  // Tap registers: loaded once per timestep and held for the whole conv run
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NTAP; n++) begin
        tap_q[n] <= '0;
      end
    end else if (state_q == S_LOAD) begin
      for (int n = 0; n < NTAP; n++) begin
        tap_q[n] <= tap_d[n];
      end
    end
  end

`ifdef DTS_ZERO_PAD_EN
  // Sample history ring, cleared on reset so padding reads are well defined
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= '0;
      end
    end else if (w_accept) begin
      ring_q[wp_q] <= dts_io.in_data;
    end
  end
`else
  // Sample history ring, left uninitialised: early taps are don't-care
  always_ff @(posedge clk) begin
    if (w_accept) begin
      ring_q[wp_q] <= dts_io.in_data;
    end
  end
`endif

  assign dts_io.in_ready        = (state_q == S_IDLE);
  assign dts_io.conv_rst        = conv_rst_q;
  assign dts_io.conv_apply_relu = dts_io.relu_en;
  assign dts_io.conv_a0         = tap_q[0];
  assign dts_io.conv_a1         = tap_q[1];
  assign dts_io.conv_a2         = tap_q[2];
  assign dts_io.conv_a3         = tap_q[3];
  assign dts_io.out_v           = (state_q == S_EMIT);
  assign dts_io.out_data        = out_data_q;
  assign dts_io.sample_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_dilated_tap_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dilated_tap_scheduler
//  Description : Self-checking bench for dilated_tap_scheduler. Two DUTs
//                (DILATION 1 with conv latency 10, DILATION 2 with latency 3),
//                each driven by an echoing conv1d model; taps and results are
//                predicted from a per-instance sample history.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dilated_tap_scheduler;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int DW = D * W;

`ifdef DTS_ZERO_PAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Stimulus driven by the bench, one entry per DUT instance
  logic          rst_a   [2];
  logic          tin_v   [2];
  logic [DW-1:0] tin_data[2];
  logic          trelu   [2];
  logic          ovr_en  [2];
  logic [DW-1:0] ovr_val;

  // Observed DUT outputs
  logic          ready [2];
  logic          crst  [2];
  logic          ov    [2];
  logic          relu_o[2];
  logic [DW-1:0] taps  [2][4];
  logic [DW-1:0] odata [2];
  logic [15:0]   scnt  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 10 : 3;
    dilated_tap_scheduler_if #(.W(W), .D(D)) bus ();
    dilated_tap_scheduler #(.W(W), .D(D), .DILATION(g + 1)) u_dut (
      .clk    (clk),
      .rst    (rst_a[g]),
      .dts_io (bus.slave)
    );

    // conv1d model: out_v rises LAT cycles after its reset drops, then holds
    int   ccnt = 0;
    logic cov  = 1'b0;
    always @(posedge clk) begin
      if (bus.conv_rst) begin
        ccnt <= 0;
        cov  <= 1'b0;
      end else begin
        if (ccnt < LAT) ccnt <= ccnt + 1;
        if (ccnt + 1 >= LAT) cov <= 1'b1;
      end
    end

    assign bus.in_v       = tin_v[g];
    assign bus.in_data    = tin_data[g];
    assign bus.relu_en    = trelu[g];
    assign bus.conv_out_v = cov;
    assign bus.conv_out   = ovr_en[g] ? ovr_val : bus.conv_a3;

    assign ready[g]   = bus.in_ready;
    assign crst[g]    = bus.conv_rst;
    assign ov[g]      = bus.out_v;
    assign relu_o[g]  = bus.conv_apply_relu;
    assign taps[g][0] = bus.conv_a0;
    assign taps[g][1] = bus.conv_a1;
    assign taps[g][2] = bus.conv_a2;
    assign taps[g][3] = bus.conv_a3;
    assign odata[g]   = bus.out_data;
    assign scnt[g]    = bus.sample_count;
  end

  // Reference model: full history of accepted vectors since last reset
  logic [DW-1:0] hmem[2][512];
  int            hn  [2];
  int            ecnt[2];

  int ovc0 = 0;
  always @(negedge clk) if (ov[0] === 1'b1) ovc0 <= ovc0 + 1;

  function automatic int lat(input int u);
    return (u == 0) ? 10 : 3;
  endfunction

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] splat(input int v);
    logic [15:0] e;
    e = v[15:0];
    return {D{e}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int u);
    @(posedge clk); #1;
    rst_a[u] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_conv_rst", crst[u], 1);
    chk("rst_in_ready", ready[u], 1);
    chk("rst_out_v", ov[u], 0);
    chk("rst_count", scnt[u], 0);
    chk("rst_out_data", odata[u], 0);
    for (int k = 0; k < 4; k++) chk($sformatf("rst_tap%0d", k), taps[u][k], 0);
    @(posedge clk); #1;
    rst_a[u] = 1'b0;
    @(negedge clk);
    chk("conv_rst_after_rst", crst[u], 1);
    @(negedge clk);
    chk("conv_rst_release", crst[u], 0);
    hn[u]   = 0;
    ecnt[u] = 0;
  endtask

  // One full timestep: accept, check taps, conv reset, latency, result, count
  task automatic sample(input int u, input logic [DW-1:0] x);
    int            acc, n, off;
    logic [DW-1:0] ex;
    @(posedge clk); #1;
    tin_v[u]    = 1'b1;
    tin_data[u] = x;
    n = 0;
    @(negedge clk);
    while (ready[u] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("accept_ready", ready[u], 1);
    acc = cyc;
    hmem[u][hn[u]] = x;
    hn[u]++;
    @(posedge clk); #1;
    tin_v[u]    = 1'b0;
    tin_data[u] = rnd();
    @(negedge clk);                       // LOAD
    @(negedge clk);                       // CONV_RST
    chk("conv_rst_pulse", crst[u], 1);
    for (int k = 0; k < 4; k++) begin
      off = (3 - k) * (u + 1);
      ex  = (off < hn[u]) ? hmem[u][hn[u] - 1 - off] : '0;
      if (off < hn[u] || ZP) chk($sformatf("tap%0d", k), taps[u][k], ex);
    end
    @(negedge clk);                       // first WAIT cycle
    chk("conv_rst_low", crst[u], 0);
    trelu[u] = ~trelu[u];
    #1 chk("relu_follow", relu_o[u], trelu[u]);
    n = 0;
    while (ov[u] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("latency", cyc - acc, lat(u) + 4);
    ex = ovr_en[u] ? ovr_val : x;
    chk("out_data", odata[u], ex);
    ecnt[u]++;
    @(negedge clk);
    chk("out_v_one_cycle", ov[u], 0);
    chk("sample_count", scnt[u], ecnt[u]);
    chk("out_data_hold", odata[u], ex);
  endtask

  initial begin
    int            acc, n, prev, nacc, nout, base, ovb;
    logic [DW-1:0] pend;

    for (int u = 0; u < 2; u++) begin
      rst_a[u] = 1'b1; tin_v[u] = 1'b0; tin_data[u] = '0;
      trelu[u] = 1'b0; ovr_en[u] = 1'b0; hn[u] = 0; ecnt[u] = 0;
    end
    ovr_val = {D{16'h8000}};

    do_reset(0);
    do_reset(1);

    // DILATION=1: x = 1,2,3,4
    for (int v = 1; v <= 4; v++) sample(0, splat(v));

    // DILATION=2: ten vectors valued by index, ring wraps at 7
    for (int v = 0; v < 10; v++) sample(1, splat(v));

    // Random vectors on both instances
    repeat (6) sample(0, rnd());
    repeat (3) sample(1, rnd());

    // Negative conv result -8.0 in every lane, held until next capture
    ovr_en[0] = 1'b1;
    sample(0, rnd());
    ovr_en[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("neg_hold", odata[0], ovr_val);
    end
    sample(0, rnd());

    // Reset two cycles into WAIT: result discarded, history restarts
    @(posedge clk); #1;
    tin_v[0] = 1'b1; tin_data[0] = rnd();
    n = 0;
    @(negedge clk);
    while (ready[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("abort_accept", ready[0], 1);
    acc = cyc;
    @(posedge clk); #1;
    tin_v[0] = 1'b0;
    while (cyc < acc + 5) @(negedge clk);
    ovb = ovc0;
    do_reset(0);
    repeat (20) @(negedge clk);
    chk("abort_no_out_v", ovc0 - ovb, 0);
    chk("abort_count", scnt[0], 0);
    sample(0, rnd());

    // in_v held high: back-to-back accepts spaced L+5
    base = ecnt[0];
    prev = -1; nacc = 0; nout = 0;
    @(posedge clk); #1;
    tin_v[0] = 1'b1; tin_data[0] = rnd();
    for (int c = 0; c < 300 && nout < 5; c++) begin
      @(negedge clk);
      if (ov[0] === 1'b1) begin
        nout++;
        chk("stream_data", odata[0], pend);
      end
      if (ready[0] === 1'b1 && tin_v[0]) begin
        if (prev >= 0) chk("stream_spacing", cyc - prev, 15);
        prev = cyc;
        pend = tin_data[0];
        hmem[0][hn[0]] = pend;
        hn[0]++;
        nacc++;
        @(posedge clk); #1;
        tin_data[0] = rnd();
        if (nacc == 5) tin_v[0] = 1'b0;
      end
    end
    chk("stream_outputs", nout, 5);
    @(negedge clk);
    ecnt[0] += 5;
    chk("stream_count", scnt[0], base + 5);

    // One more timestep after streaming uses the streamed history
    sample(0, rnd());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
